// File: rtl/spi_txn_sequencer.sv
// Register-transaction front end for the SPI bit engine: frames one command,
// launches the engine, collects the read data or a timeout, then enforces an idle gap.
module spi_txn_sequencer #(
   parameter int MAX_BITS       = 1024,
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 32,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_rw,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [7:0]          cmd_dbits,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                eng_start,
   output logic [15:0]         eng_bit_count,
   output logic [MAX_BITS-1:0] eng_tx_bits,
   input  logic [MAX_BITS-1:0] eng_rx_bits,
   input  logic                eng_busy,
   input  logic                eng_done
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_RESP   = 3'd3,
      ST_GAP    = 3'd4
   } state_e;

   // One counter serves both the WAIT timeout and the GAP idle period.
   localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rw_q, rw_d;
   logic [7:0]          dbits_q, dbits_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                eng_start_q, eng_start_d;
   logic [15:0]         eng_bit_count_q, eng_bit_count_d;
   logic [MAX_BITS-1:0] eng_tx_bits_q, eng_tx_bits_d;
   logic                legal_s;
   logic                rx_unused_s;

   function automatic logic [DATA_W-1:0] data_mask(input logic [7:0] dbits);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (i < int'(dbits)) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

   function automatic logic [MAX_BITS-1:0] build_frame(input logic              rw,
                                                       input logic [ADDR_W-1:0] addr,
                                                       input logic [DATA_W-1:0] wdata,
                                                       input logic [7:0]        dbits);
      logic [DATA_W-1:0] data;
      if (rw) begin
         data = '0;
      end else begin
         data = wdata & data_mask(dbits);
      end
      return MAX_BITS'(data)
           | (MAX_BITS'(addr) << dbits)
           | (MAX_BITS'(rw) << (ADDR_W + int'(dbits)));
   endfunction

   assign legal_s     = (cmd_dbits != 8'd0) && (int'(cmd_dbits) <= DATA_W);
   assign rx_unused_s = ^eng_rx_bits[MAX_BITS-1:DATA_W];

   // Next-state and next-output computation for the transaction FSM.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      rw_d            = rw_q;
      dbits_d         = dbits_q;
      rsp_valid_d     = rsp_valid_q;
      rsp_rdata_d     = rsp_rdata_q;
      rsp_err_d       = rsp_err_q;
      eng_start_d     = 1'b0;
      eng_bit_count_d = eng_bit_count_q;
      eng_tx_bits_d   = eng_tx_bits_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               rw_d    = cmd_rw;
               dbits_d = cmd_dbits;
               if (!legal_s) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  state_d     = ST_RESP;
               end else begin
                  eng_tx_bits_d   = build_frame(cmd_rw, cmd_addr, cmd_wdata, cmd_dbits);
                  eng_bit_count_d = 16'(1 + ADDR_W + int'(cmd_dbits));
                  // Launch straight from the accept cycle so an idle engine starts at T+1.
                  if (!eng_busy) begin
                     eng_start_d = 1'b1;
                     cnt_d       = '0;
                     state_d     = ST_WAIT;
                  end else begin
                     state_d = ST_LAUNCH;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            if (!eng_busy) begin
               eng_start_d = 1'b1;
               cnt_d       = '0;
               state_d     = ST_WAIT;
            end else begin
               state_d = ST_LAUNCH;
            end
         end
         ST_WAIT: begin
            if (eng_done) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               if (rw_q) begin
                  rsp_rdata_d = eng_rx_bits[DATA_W-1:0] & data_mask(dbits_q);
               end else begin
                  rsp_rdata_d = '0;
               end
               state_d = ST_RESP;
            end else if (cnt_q == TO_LAST) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cnt_d       = '0;
               if (GAP_CYCLES == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_GAP;
               end
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
   end

   // State and registered-output flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         rw_q            <= 1'b0;
         dbits_q         <= 8'd0;
         cmd_ready_q     <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rsp_rdata_q     <= '0;
         rsp_err_q       <= 1'b0;
         eng_start_q     <= 1'b0;
         eng_bit_count_q <= 16'd0;
         eng_tx_bits_q   <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         rw_q            <= rw_d;
         dbits_q         <= dbits_d;
         cmd_ready_q     <= cmd_ready_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_rdata_q     <= rsp_rdata_d;
         rsp_err_q       <= rsp_err_d;
         eng_start_q     <= eng_start_d;
         eng_bit_count_q <= eng_bit_count_d;
         eng_tx_bits_q   <= eng_tx_bits_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_err       = rsp_err_q;
   assign eng_start     = eng_start_q;
   assign eng_bit_count = eng_bit_count_q;
   assign eng_tx_bits   = eng_tx_bits_q;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer: vector table plus hand-written
// timeout, backpressure/gap, launch-hold and mid-transaction reset sequences.
module tb_spi_txn_sequencer;

   localparam int MAX_BITS       = 64;
   localparam int ADDR_W         = 8;
   localparam int DATA_W         = 32;
   localparam int GAP_CYCLES     = 4;
   localparam int TIMEOUT_CYCLES = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                cmd_valid, cmd_ready, cmd_rw;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_wdata;
   logic [7:0]          cmd_dbits;
   logic                rsp_valid, rsp_ready, rsp_err;
   logic [DATA_W-1:0]   rsp_rdata;
   logic                eng_start, eng_busy, eng_done;
   logic [15:0]         eng_bit_count;
   logic [MAX_BITS-1:0] eng_tx_bits, eng_rx_bits;

   logic                model_busy = 1'b0;
   logic                model_done = 1'b0;
   logic [MAX_BITS-1:0] model_rx   = '0;
   logic                force_busy, inj_done, eng_auto;
   logic [MAX_BITS-1:0] rx_val;
   int                  ecnt       = 0;
   int unsigned         start_cnt  = 0;
   logic [15:0]         cap_count  = 16'd0;
   logic [MAX_BITS-1:0] cap_tx     = '0;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rw;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [7:0]  dbits;
      logic [63:0] rx;
      logic        exp_start;
      logic [15:0] exp_count;
      logic [63:0] exp_tx;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   assign eng_busy    = model_busy | force_busy;
   assign eng_done    = model_done | inj_done;
   assign eng_rx_bits = model_rx;

   spi_txn_sequencer #(
      .MAX_BITS(MAX_BITS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_dbits(cmd_dbits),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .eng_start(eng_start), .eng_bit_count(eng_bit_count), .eng_tx_bits(eng_tx_bits),
      .eng_rx_bits(eng_rx_bits), .eng_busy(eng_busy), .eng_done(eng_done)
   );

   // Engine model: busy for four cycles after a start, then a done pulse with rx data.
   always @(posedge clk) begin
      model_done <= 1'b0;
      if (rst) begin
         model_busy <= 1'b0;
         ecnt       <= 0;
      end else if (eng_start && eng_auto) begin
         model_busy <= 1'b1;
         ecnt       <= 4;
      end else if (model_busy) begin
         if (ecnt == 1) begin
            model_busy <= 1'b0;
            model_done <= 1'b1;
            model_rx   <= rx_val;
         end else begin
            ecnt <= ecnt - 1;
         end
      end
   end

   // Count start pulses and capture the frame presented with each.
   always @(posedge clk) begin
      if (eng_start) begin
         start_cnt <= start_cnt + 1;
         cap_count <= eng_bit_count;
         cap_tx    <= eng_tx_bits;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_cmd(input logic rw, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [7:0] dbits, input string tag);
      int k;
      k = 0;
      while (!cmd_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_dbits = dbits;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, output int k);
      k = 0;
      while (!rsp_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1));
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int unsigned s0;
      int          k;
      s0     = start_cnt;
      rx_val = v.rx;
      send_cmd(v.rw, v.addr, v.wdata, v.dbits, tag);
      check({tag, "_start_lat"}, 64'(eng_start), 64'(v.exp_start));
      wait_rsp(tag, k);
      check({tag, "_err"}, 64'(rsp_err), 64'(v.exp_err));
      check({tag, "_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
      check({tag, "_starts"}, 64'(start_cnt - s0), 64'(v.exp_start));
      if (v.exp_start) begin
         check({tag, "_bit_count"}, 64'(cap_count), 64'(v.exp_count));
         check({tag, "_tx_bits"}, cap_tx, v.exp_tx);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_rsp_drop"}, 64'(rsp_valid), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          k;
      int unsigned s0;
      logic        ok;

      vecs[0] = '{1'b0, 8'h5A, 32'h000000A5, 8'd8,  64'h0,                  1'b1, 16'd17, 64'h05AA5,          1'b0, 32'h0};
      vecs[1] = '{1'b1, 8'h3C, 32'h0,        8'd16, 64'h000000000000BEEF,   1'b1, 16'd25, 64'h13C0000,        1'b0, 32'h0000BEEF};
      vecs[2] = '{1'b0, 8'h12, 32'h0000FFFF, 8'd0,  64'h0,                  1'b0, 16'd0,  64'h0,              1'b1, 32'h0};
      vecs[3] = '{1'b1, 8'h12, 32'h0000FFFF, 8'd33, 64'hFFFFFFFFFFFFFFFF,   1'b0, 16'd0,  64'h0,              1'b1, 32'h0};
      vecs[4] = '{1'b0, 8'hFF, 32'hFFFFFFFF, 8'd32, 64'hFFFFFFFFFFFFFFFF,   1'b1, 16'd41, 64'hFFFFFFFFFF,     1'b0, 32'h0};
      vecs[5] = '{1'b1, 8'h01, 32'hFFFFFFFF, 8'd1,  64'hFFFFFFFFFFFFFFFF,   1'b1, 16'd10, 64'h202,            1'b0, 32'h1};
      vecs[6] = '{1'b0, 8'h80, 32'hFFFFFF12, 8'd4,  64'h0,                  1'b1, 16'd13, 64'h802,            1'b0, 32'h0};
      vecs[7] = '{1'b1, 8'h00, 32'h0,        8'd32, 64'h12345678DEADBEEF,   1'b1, 16'd41, 64'h10000000000,    1'b0, 32'hDEADBEEF};
      vecs[8] = '{1'b0, 8'h44, 32'h1,        8'd255, 64'h0,                 1'b0, 16'd0,  64'h0,              1'b1, 32'h0};

      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_rw     = 1'b0;
      cmd_addr   = '0;
      cmd_wdata  = '0;
      cmd_dbits  = 8'd0;
      rsp_ready  = 1'b0;
      force_busy = 1'b0;
      inj_done   = 1'b0;
      eng_auto   = 1'b1;
      rx_val     = '0;

      repeat (2) @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_err", 64'(rsp_err), 64'(0));
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
      check("rst_eng_start", 64'(eng_start), 64'(0));
      check("rst_bit_count", 64'(eng_bit_count), 64'(0));
      check("rst_tx_bits", eng_tx_bits, 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", 64'(cmd_ready), 64'(1));

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Timeout: engine never answers.
      eng_auto = 1'b0;
      s0 = start_cnt;
      send_cmd(1'b0, 8'h22, 32'h1, 8'd8, "to");
      check("to_start", 64'(eng_start), 64'(1));
      wait_rsp("to", k);
      check("to_latency", 64'(k), 64'(16));
      check("to_err", 64'(rsp_err), 64'(1));
      check("to_rdata", 64'(rsp_rdata), 64'(0));
      check("to_starts", 64'(start_cnt - s0), 64'(1));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      inj_done  = 1'b1;
      @(negedge clk);
      inj_done  = 1'b0;
      repeat (2) @(negedge clk);
      check("to_late_done", 64'(rsp_valid), 64'(0));

      // Backpressure and gap.
      eng_auto = 1'b1;
      rx_val   = 64'hFFFFFFFFFFFFFF5C;
      send_cmd(1'b1, 8'h11, 32'h0, 8'd8, "bp");
      wait_rsp("bp", k);
      ok = 1'b1;
      repeat (10) begin
         if (!(rsp_valid && rsp_rdata == 32'h5C && !rsp_err && !cmd_ready)) ok = 1'b0;
         @(negedge clk);
      end
      check("bp_stable", 64'(ok), 64'(1));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp_rsp_drop", 64'(rsp_valid), 64'(0));
      k = 0;
      while (!cmd_ready && k < 50) begin
         k++;
         @(negedge clk);
      end
      check("gap_len", 64'(k), 64'(GAP_CYCLES));

      // Launch held off while the engine reports busy.
      force_busy = 1'b1;
      rx_val     = '0;
      send_cmd(1'b0, 8'h99, 32'h7, 8'd3, "lh");
      ok = 1'b1;
      repeat (5) begin
         if (eng_start) ok = 1'b0;
         @(negedge clk);
      end
      check("lh_no_start", 64'(ok), 64'(1));
      force_busy = 1'b0;
      @(negedge clk);
      check("lh_start", 64'(eng_start), 64'(1));
      check("lh_count", 64'(eng_bit_count), 64'(12));
      check("lh_tx", eng_tx_bits, 64'h4CF);
      @(negedge clk);
      check("lh_pulse_width", 64'(eng_start), 64'(0));
      wait_rsp("lh", k);
      check("lh_err", 64'(rsp_err), 64'(0));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // Reset in the middle of WAIT.
      eng_auto = 1'b0;
      send_cmd(1'b0, 8'h77, 32'h3, 8'd8, "mr");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      ok = (!cmd_ready && !rsp_valid && !rsp_err && rsp_rdata == 32'h0 && !eng_start
            && eng_bit_count == 16'd0 && eng_tx_bits == 64'h0);
      check("mr_reset_outputs", 64'(ok), 64'(1));
      rst = 1'b0;
      s0 = start_cnt;
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      repeat (2) @(negedge clk);
      check("mr_late_done", 64'(rsp_valid), 64'(0));
      check("mr_no_start", 64'(start_cnt - s0), 64'(0));
      eng_auto = 1'b1;
      run_vec(vecs[0], "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
